rr_pipe_arbiter: RTL and testbench

N-input arbiter for address-request channels, the parametrised successor to the 2-input fixed-priority request arbiter. It selects one of N_IN valid/ready request inputs, with either fixed-priority or round-robin policy chosen at elaboration time. The winner is captured in a one-entry registered output stage, which gives a one-cycle latency and full throughput. It sits between the per-requester queues and the shared downstream request port, for example a PTW or TLB refill port.

---
 rtl/rr_pipe_arbiter.sv | 95 +++++++++
 tb/tb_rr_pipe_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_pipe_arbiter.sv
// N-input valid/ready request arbiter with a one-entry registered output stage.
// Policy is fixed priority (lowest index) or round-robin, chosen at elaboration.
module rr_pipe_arbiter #(
   parameter int unsigned N_IN     = 4,
   parameter int unsigned ADDR_W   = 27,
   parameter int unsigned RR_MODE  = 1,
   parameter int unsigned CHOSEN_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_IN-1:0]          io_in_valid,
   output logic [N_IN-1:0]          io_in_ready,
   input  logic [N_IN-1:0]          io_in_bits_valid,
   input  logic [N_IN*ADDR_W-1:0]   io_in_bits_bits_addr,
   input  logic                     io_out_ready,
   output logic                     io_out_valid,
   output logic                     io_out_bits_valid,
   output logic [ADDR_W-1:0]        io_out_bits_bits_addr,
   output logic [CHOSEN_W-1:0]      io_chosen
);

   logic                out_full;
   logic                accept_en;
   logic [CHOSEN_W-1:0] rr_ptr;
   logic [CHOSEN_W-1:0] ptr_next;
   logic [CHOSEN_W-1:0] winner;
   logic [N_IN-1:0]     grant;
   logic                any_grant;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_bits_valid;

   assign io_out_valid = out_full;
   assign accept_en    = ~out_full | io_out_ready;
   // Reset gates the accept so nothing transfers while the stage is being cleared.
   assign io_in_ready  = grant & {N_IN{accept_en & ~reset}};

   // Grant search: first valid input scanning upward from the start index, wrapping.
   always_comb begin : grant_sel
      int unsigned         pos;
      logic [CHOSEN_W-1:0] idx;
      grant     = '0;
      winner    = '0;
      any_grant = 1'b0;
      pos       = 0;
      idx       = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         pos = ((RR_MODE != 0) ? 32'(rr_ptr) : 32'd0) + k;
         if (pos >= N_IN) pos = pos - N_IN;
         idx = CHOSEN_W'(pos);
         if (!any_grant && io_in_valid[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            winner     = idx;
         end
      end
   end

   // Payload mux driven by the one-hot grant.
   always_comb begin
      sel_addr       = '0;
      sel_bits_valid = 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (grant[i]) begin
            sel_addr       = sel_addr | io_in_bits_bits_addr[i*ADDR_W +: ADDR_W];
            sel_bits_valid = sel_bits_valid | io_in_bits_valid[i];
         end
      end
   end

   // Pointer advances to the slot after the winner, wrapping for any N_IN.
   always_comb begin
      ptr_next = winner + CHOSEN_W'(1);
      if (32'(winner) == N_IN - 1) ptr_next = '0;
   end

   // Output stage: replace on accept, drain when nothing is granted, hold on stall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_full              <= 1'b0;
         io_out_bits_valid     <= 1'b0;
         io_out_bits_bits_addr <= '0;
         io_chosen             <= '0;
         rr_ptr                <= '0;
      end else if (accept_en) begin
         out_full <= any_grant;
         if (any_grant) begin
            io_out_bits_valid     <= sel_bits_valid;
            io_out_bits_bits_addr <= sel_addr;
            io_chosen             <= winner;
            if (RR_MODE != 0) rr_ptr <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share the stimulus.
module tb_rr_pipe_arbiter;

   localparam int unsigned N      = 4;
   localparam int unsigned AW     = 27;
   localparam int unsigned CW     = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_bits_valid;
   logic [N*AW-1:0] in_addr;
   logic            out_ready;

   logic [N-1:0]    r_in_ready, f_in_ready;
   logic            r_out_valid, f_out_valid;
   logic            r_bits_valid, f_bits_valid;
   logic [AW-1:0]   r_addr, f_addr;
   logic [CW-1:0]   r_chosen, f_chosen;

   logic [AW-1:0]   addr_tab [N];
   logic [N-1:0]    bv_tab;
   logic [AW-1:0]   held_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   rr_pipe_arbiter #(.N_IN(N), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(r_in_ready),
      .io_in_bits_valid(in_bits_valid), .io_in_bits_bits_addr(in_addr),
      .io_out_ready(out_ready), .io_out_valid(r_out_valid),
      .io_out_bits_valid(r_bits_valid), .io_out_bits_bits_addr(r_addr),
      .io_chosen(r_chosen)
   );

   rr_pipe_arbiter #(.N_IN(N), .ADDR_W(AW), .RR_MODE(0)) dut_fx (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(f_in_ready),
      .io_in_bits_valid(in_bits_valid), .io_in_bits_bits_addr(in_addr),
      .io_out_ready(out_ready), .io_out_valid(f_out_valid),
      .io_out_bits_valid(f_bits_valid), .io_out_bits_bits_addr(f_addr),
      .io_chosen(f_chosen)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_addr();
      for (int i = 0; i < N; i++) in_addr[i*AW +: AW] = addr_tab[i];
   endtask

   initial begin
      reset         = 1'b1;
      out_ready     = 1'b0;
      in_valid      = '0;
      bv_tab        = 4'b0101;
      in_bits_valid = bv_tab;
      for (int i = 0; i < N; i++) addr_tab[i] = AW'(27'h0ABC000 + 27'(i * 27'h111));
      load_addr();

      // Held in reset with requests present: no accept, no output.
      #2;
      in_valid = 4'b1111;
      #1;
      chk("reset_in_ready", 32'(r_in_ready), 32'h0);
      chk("reset_out_valid", 32'(r_out_valid), 32'h0);
      in_valid = '0;
      #10;
      reset = 1'b0;

      // Test 1: idle after release.
      out_ready = 1'b1;
      step();
      chk("idle_out_valid", 32'(r_out_valid), 32'h0);
      chk("idle_chosen", 32'(r_chosen), 32'h0);
      chk("idle_in_ready", 32'(r_in_ready), 32'h0);
      step();
      chk("idle_out_valid_2", 32'(r_out_valid), 32'h0);

      // Tests 2/3: all inputs valid, downstream always ready.
      in_valid = 4'b1111;
      #1;
      chk("rr_first_ready", 32'(r_in_ready), 32'h1);
      for (int k = 0; k < 6; k++) begin
         chk("fx_ready", 32'(f_in_ready), 32'h1);
         step();
         chk("rr_valid", 32'(r_out_valid), 32'h1);
         chk("rr_chosen", 32'(r_chosen), 32'(k % 4));
         chk("rr_addr", 32'(r_addr), 32'(addr_tab[k % 4]));
         chk("rr_bits_valid", 32'(r_bits_valid), 32'(bv_tab[k % 4]));
         chk("rr_next_ready", 32'(r_in_ready), 32'(1 << ((k + 1) % 4)));
         chk("fx_chosen", 32'(f_chosen), 32'h0);
         chk("fx_addr", 32'(f_addr), 32'(addr_tab[0]));
      end

      // Drain both stages; rr pointer now at 2.
      in_valid = '0;
      step();
      chk("drain_valid", 32'(r_out_valid), 32'h0);

      // Test 4: single request on input 2, downstream stalled for 3 cycles.
      addr_tab[2] = 27'h5A5A5A1;
      load_addr();
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      #1;
      chk("stall_enq_ready", 32'(r_in_ready), 32'h4);
      step();
      held_addr = 27'h5A5A5A1;
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", 32'(r_out_valid), 32'h1);
         chk("stall_addr", 32'(r_addr), 32'(held_addr));
         chk("stall_chosen", 32'(r_chosen), 32'h2);
         chk("stall_in_ready", 32'(r_in_ready), 32'h0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("release_ready_comb", 32'(r_in_ready), 32'h4);
      step();
      chk("replace_valid", 32'(r_out_valid), 32'h1);
      chk("replace_chosen", 32'(r_chosen), 32'h2);

      // Test 5: only input 3 (pointer wraps), then inputs 0 and 2.
      in_valid = 4'b1000;
      step();
      chk("wrap_chosen", 32'(r_chosen), 32'h3);
      chk("fx_only3", 32'(f_chosen), 32'h3);
      in_valid = 4'b0101;
      #1;
      chk("wrap_ready", 32'(r_in_ready), 32'h1);
      step();
      chk("after_wrap_0", 32'(r_chosen), 32'h0);
      chk("after_wrap_ready", 32'(r_in_ready), 32'h4);
      step();
      chk("after_wrap_2", 32'(r_chosen), 32'h2);
      chk("after_wrap_addr", 32'(r_addr), 32'(27'h5A5A5A1));
      chk("fx_02", 32'(f_chosen), 32'h0);

      // Test 6: asynchronous reset with a held entry.
      out_ready = 1'b0;
      step();
      chk("pre_reset_full", 32'(r_out_valid), 32'h1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_out_valid", 32'(r_out_valid), 32'h0);
      chk("async_in_ready", 32'(r_in_ready), 32'h0);
      chk("async_chosen", 32'(r_chosen), 32'h0);
      chk("async_addr", 32'(r_addr), 32'h0);
      #10;
      reset     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("post_reset_ready", 32'(r_in_ready), 32'h1);
      step();
      chk("post_reset_chosen", 32'(r_chosen), 32'h0);
      step();
      chk("post_reset_chosen_1", 32'(r_chosen), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
